// File: rtl/piano_voice_mixer.sv
`default_nettype none
// ============================================================================
// piano_voice_mixer: one square-wave voice per held key, summed into a signed
// 32-bit PCM sample for both Audio_Controller channels.   Rev 1.0
// ============================================================================
module piano_voice_mixer #(
  parameter int                     NUM_KEYS     = 10,
  parameter logic signed [31:0]     AMPLITUDE    = 32'sd10000000,
  parameter logic [NUM_KEYS*17-1:0] HALF_PERIODS = {17'd37921, 17'd42566, 17'd47778, 17'd50619, 17'd56818,
                                                    17'd63776, 17'd71586, 17'd75843, 17'd85131, 17'd95556}
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [NUM_KEYS-1:0] keys_in,
  input  logic                audio_out_allowed,
  output logic signed [31:0]  sound,
  output logic                write_audio_out,
  output logic [3:0]          active_count
);

  logic [NUM_KEYS-1:0] keys_q;
  logic signed [31:0]  voice_v [NUM_KEYS];
  logic signed [35:0]  mix_d;
  logic [3:0]          count_d;
  logic                valid_q;
  logic                mix_unused_w;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      keys_q <= '0;
    end else begin
      keys_q <= keys_in;
    end
  end

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_voice
    localparam logic [16:0] c_half = HALF_PERIODS[gi*17 +: 17];
    // Half-periods of 0 or 1 collapse to a terminal count of 0: toggle every edge.
    localparam logic [16:0] c_term = (c_half > 17'd1) ? (c_half - 17'd1) : 17'd0;

    logic [16:0] cnt_q;
    logic        phase_q;

    always_ff @(posedge clock) begin
      if (!resetn) begin
        cnt_q   <= '0;
        phase_q <= 1'b0;
      end else if (!keys_q[gi]) begin
        cnt_q   <= '0;
        phase_q <= 1'b0;
      end else if (cnt_q == c_term) begin
        cnt_q   <= '0;
        phase_q <= ~phase_q;
      end else begin
        cnt_q   <= cnt_q + 17'd1;
      end
    end

    assign voice_v[gi] = !keys_q[gi] ? 32'sd0 : (phase_q ? AMPLITUDE : -AMPLITUDE);
  end

  always_comb begin
    mix_d   = '0;
    count_d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      mix_d   = mix_d + {{4{voice_v[i][31]}}, voice_v[i]};
      count_d = count_d + {3'b000, keys_q[i]};
    end
  end

  // Guard bits exist only to keep the sum exact; the voice set never exceeds 31 bits.
  assign mix_unused_w = ^mix_d[35:32];

  always_ff @(posedge clock) begin
    if (!resetn) begin
      sound        <= '0;
      active_count <= '0;
      valid_q      <= 1'b0;
    end else begin
      sound        <= mix_d[31:0];
      active_count <= count_d;
      valid_q      <= 1'b1;
    end
  end

  assign write_audio_out = valid_q & audio_out_allowed;

endmodule
`default_nettype wire

// File: tb/tb_piano_voice_mixer.sv
`default_nettype none
// ============================================================================
// tb_piano_voice_mixer: scoreboard bench for piano_voice_mixer.   Rev 1.0
// ============================================================================
module tb_piano_voice_mixer;

  localparam int NK       = 10;
  localparam int AMP      = 100;
  localparam int FULL_END = 42600;
  localparam logic [NK*17-1:0] HP_TB = {17'd1, 17'd0, {8{17'd4}}};

  logic              clock = 1'b0;
  logic              resetn;
  logic [NK-1:0]     keys_in;
  logic              audio_out_allowed;
  logic signed [31:0] sound;
  logic              write_audio_out;
  logic [3:0]        active_count;

  logic              resetn_f;
  logic [NK-1:0]     keys_f = '1;
  logic              allowed_f = 1'b1;
  logic signed [31:0] sound_f;
  logic              write_f;
  logic [3:0]        count_f;

  always #5 clock = ~clock;

  piano_voice_mixer #(
    .NUM_KEYS(NK), .AMPLITUDE(32'sd100), .HALF_PERIODS(HP_TB)
  ) dut (
    .clock(clock), .resetn(resetn), .keys_in(keys_in),
    .audio_out_allowed(audio_out_allowed), .sound(sound),
    .write_audio_out(write_audio_out), .active_count(active_count)
  );

  piano_voice_mixer dut_full (
    .clock(clock), .resetn(resetn_f), .keys_in(keys_f),
    .audio_out_allowed(allowed_f), .sound(sound_f),
    .write_audio_out(write_f), .active_count(count_f)
  );

  typedef struct {
    int due;
    int snd;
    int cnt;
  } exp_t;

  exp_t          sbq[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            edge_n = 0;
  int            full_cyc = 0;
  int            press_edge [NK];
  logic [NK-1:0] prev_k = '0;
  logic          valid_m = 1'b0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  function automatic int heff(input int i);
    return (i >= 8) ? 1 : 4;
  endfunction

  // Drive one input vector, model its effect two edges later, then check after the edge.
  task automatic tick(input logic [NK-1:0] k, input logic al);
    exp_t ent;
    int   e;
    int   s;
    bit   first;
    keys_in           = k;
    audio_out_allowed = al;
    e = edge_n + 1;
    if (!resetn) begin
      sbq.delete();
      prev_k  = '0;
      valid_m = 1'b0;
    end else begin
      s = 0;
      for (int i = 0; i < NK; i++) begin
        if (k[i]) begin
          if (!prev_k[i]) press_edge[i] = e;
          s += ((((e - press_edge[i]) / heff(i)) % 2) == 1) ? AMP : -AMP;
        end
      end
      ent.due = e + 1;
      ent.snd = s;
      ent.cnt = $countones(k);
      sbq.push_back(ent);
      prev_k = k;
    end
    first = resetn && !valid_m;
    @(posedge clock);
    edge_n++;
    @(negedge clock);
    if (!resetn) begin
      check("rst_sound", sound, 0);
      check("rst_count", active_count, 0);
      check("rst_write", write_audio_out, 0);
    end else begin
      valid_m = 1'b1;
      if (first) begin
        check("first_sound", sound, 0);
        check("first_count", active_count, 0);
      end
      check("write", write_audio_out, al);
      if (sbq.size() > 0 && sbq[0].due == edge_n) begin
        ent = sbq.pop_front();
        check("sound", sound, ent.snd);
        check("active_count", active_count, ent.cnt);
      end
    end
  endtask

  always @(posedge clock) full_cyc <= resetn_f ? full_cyc + 1 : 0;

  // Default-parameter instance: all keys held; voice 9 (E5) toggles first, then voice 8.
  always @(negedge clock) begin
    if (resetn_f && full_cyc >= 1 && full_cyc <= FULL_END) begin
      check("full_range", longint'(sound_f >= -100000000 && sound_f <= 100000000), 1);
      case (full_cyc)
        1:     check("full_c1", sound_f, 0);
        2: begin
          check("full_c2", sound_f, -100000000);
          check("full_count", count_f, 10);
          check("full_write", write_f, 1);
        end
        37922: check("full_pre_v9", sound_f, -100000000);
        37923: check("full_v9", sound_f, -80000000);
        42567: check("full_pre_v8", sound_f, -80000000);
        42568: check("full_v8", sound_f, -60000000);
        default: ;
      endcase
    end
  end

  initial begin
    resetn            = 1'b0;
    resetn_f          = 1'b0;
    keys_in           = '1;
    audio_out_allowed = 1'b1;

    for (int i = 0; i < 3; i++) tick(10'h3FF, 1'b1);
    resetn_f = 1'b1;
    resetn   = 1'b1;
    for (int i = 0; i < 6; i++) tick(10'h3FF, 1'b1);
    for (int i = 0; i < 3; i++) tick(10'h000, 1'b1);

    for (int i = 0; i < 20; i++) tick(10'h001, 1'b1);
    for (int i = 0; i < 2; i++)  tick(10'h000, 1'b1);

    for (int i = 0; i < 12; i++) tick(10'h009, 1'b1);
    for (int i = 0; i < 6; i++)  tick(10'h001, 1'b1);

    for (int i = 0; i < 2; i++)  tick(10'h000, 1'b1);
    for (int i = 0; i < 6; i++)  tick(10'h001, 1'b1);
    for (int i = 0; i < 3; i++)  tick(10'h000, 1'b1);
    for (int i = 0; i < 10; i++) tick(10'h001, 1'b1);

    for (int i = 0; i < 2; i++)  tick(10'h000, 1'b1);
    tick(10'h002, 1'b1);
    for (int i = 0; i < 3; i++)  tick(10'h000, 1'b1);

    for (int i = 0; i < 6; i++)  tick(10'h300, 1'b1);
    for (int i = 0; i < 2; i++)  tick(10'h000, 1'b1);

    for (int i = 0; i < 40; i++) tick(10'h020, 1'($urandom_range(0, 1)));
    tick(10'h000, 1'b1);

    for (int i = 0; i < 5; i++)  tick(10'h0FF, 1'b1);
    resetn = 1'b0;
    for (int i = 0; i < 2; i++)  tick(10'h0FF, 1'b1);
    resetn = 1'b1;
    for (int i = 0; i < 11; i++) tick(10'h0FF, 1'b1);
    for (int i = 0; i < 3; i++)  tick(10'h000, 1'b1);

    while (full_cyc <= FULL_END) @(posedge clock);
    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
